fetch_pc_unit: RTL
==================

# fetch_pc_unit

Parametrised program-counter and fetch-address generator for the SPU front end. It replaces the fixed 10-bit, +2 program counter. It generates aligned fetch-group addresses for a FETCH_WIDTH-wide fetch, and marks which slots are valid after a misaligned branch target. It also buffers a taken branch that arrives during a stall, so the redirect is not lost, and supports halt/resume. It sits between the branch-resolution logic / hazard unit and the instruction-memory fetch stage.

## Interface
- PC_WIDTH, 10, PC width in instruction-address units.
- FETCH_WIDTH, 2, instructions per fetch group; power of 2, 1..8, less than 2^PC_WIDTH.
- RESET_PC, 0, boot address; its low log2(FETCH_WIDTH) bits are forced to 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  freeze the PC; a redirect presented during stall is buffered.
- is_branch  in  1  the current resolved instruction is a branch.
- branch_taken  in  1  the branch is taken; a redirect requires is_branch && branch_taken.
- PC_in  in  [0:PC_WIDTH-1]  branch target.
- halt  in  1  stop fetch (stop instruction retired).
- resume  in  1  leave the halted state.
- PC_out  out  [0:PC_WIDTH-1]  current fetch-group address, always aligned.
- slot_mask  out  [0:FETCH_WIDTH-1]  per-slot valid; bit 0 is the lowest address in the group.
- fetch_valid  out  1  PC_out and slot_mask are valid this cycle.
- redirect_pending  out  1  a buffered redirect is waiting for stall release.
- misalign  out  1  one-cycle pulse: the applied target had nonzero offset bits.
- wrap  out  1  one-cycle pulse: sequential increment wrapped past 2^PC_WIDTH.

## Operation
- OFF = log2(FETCH_WIDTH) low bits of an address. Alignment clears the OFF bits. slot_mask[i] = (i >= OFF of the target).
- States:
  - BOOT: the single cycle after reset release. Sets fetch_valid=0, PC=RESET_PC, then goes to RUN with no increment.
  - RUN: fetch_valid=1.
  - HALTED: fetch_valid=0 and PC held.
- Per-cycle priority in RUN, highest first:
  1. halt: go to HALTED, hold PC, clear pending.
  2. stall=1: hold PC, mask, and pulses low. If a redirect is present and nothing is pending, capture PC_in into pend_pc and set pending. A redirect while already pending is dropped, because the oldest branch wins.
  3. pending with stall=0: apply pend_pc (align, set mask, misalign if OFF≠0) and clear pending. A concurrent redirect in the same cycle is dropped.
  4. Redirect: apply PC_in the same way.
  5. Otherwise: PC += FETCH_WIDTH modulo 2^PC_WIDTH, slot_mask all ones, and wrap=1 if the add carried out.
- HALTED: stall, is_branch, and branch_taken are ignored. resume → RUN, and the next cycle fetches the held PC with the mask all ones. halt and resume together: halt wins.
- redirect_pending is the registered pending flag.
- Arithmetic is unsigned PC_WIDTH-bit and the carry is discarded. The target is never sign-extended.

## Timing
- Reset values (asynchronous, immediate): PC_out=RESET_PC aligned, slot_mask all ones, fetch_valid=0, redirect_pending=0, misalign=0, wrap=0, state BOOT.
- All outputs are registered. A redirect sampled at edge N appears on PC_out after edge N; latency is 1 cycle.
- A buffered redirect appears 1 cycle after the first edge that samples stall=0.
- misalign and wrap are high for exactly the cycle in which the corresponding PC_out is presented.
- rst mid-operation, in any state, discards pend_pc and restarts at BOOT.
- PC_out holds a stable value whenever fetch_valid=0.

## Test plan
- Boot (PC_WIDTH=10, FETCH_WIDTH=2): release rst → first cycle fetch_valid=0 with PC_out=0, then PC_out 0,2,4,6 with fetch_valid=1 and slot_mask=11.
- Wrap: redirect to 1020, run free → PC_out 1020,1022,0. wrap=1 only with 0. No misalign.
- Misaligned target: redirect to 261 → PC_out=260, slot_mask=01, misalign=1 for one cycle. Next cycle 262, slot_mask=11, misalign=0. With FETCH_WIDTH=4, target 263 → PC_out=260, slot_mask=0001.
- Redirect under stall: stall for cycles 1-3, taken branch to 100 in cycle 1, taken branch to 200 in cycle 2 → PC held, redirect_pending=1 from cycle 2 to release, PC_out=100 on the cycle after stall drops, then 102. 200 never appears.
- Halt/resume: halt at PC 40 → fetch_valid=0, PC_out=40. A taken branch to 500 while halted is ignored. resume → PC_out 40 then 42. halt+resume together keeps HALTED.
- Async reset mid-pending: assert rst between edges while redirect_pending=1 → outputs go to reset values without waiting for an edge. After release, BOOT then 0,2; the pending target is never applied.

Source files
------------

// File: rtl/fetch_pc_unit_if.sv
// ============================================================================
// fetch_pc_unit_if
// Control/fetch bundle between the hazard/branch logic and the PC unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fetch_pc_unit_if #(
  parameter int PC_WIDTH    = 10,
  parameter int FETCH_WIDTH = 2
);
  logic                   stall;
  logic                   is_branch;
  logic                   branch_taken;
  logic [0:PC_WIDTH-1]    PC_in;
  logic                   halt;
  logic                   resume;
  logic [0:PC_WIDTH-1]    PC_out;
  logic [0:FETCH_WIDTH-1] slot_mask;
  logic                   fetch_valid;
  logic                   redirect_pending;
  logic                   misalign;
  logic                   wrap;

  modport master (
    output stall, is_branch, branch_taken, PC_in, halt, resume,
    input  PC_out, slot_mask, fetch_valid, redirect_pending, misalign, wrap
  );

  modport slave (
    input  stall, is_branch, branch_taken, PC_in, halt, resume,
    output PC_out, slot_mask, fetch_valid, redirect_pending, misalign, wrap
  );
endinterface

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// ============================================================================
// fetch_pc_unit
// Aligned fetch-group PC generator with stall-buffered redirect and halt.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_pc_unit #(
  parameter int                  PC_WIDTH    = 10,
  parameter int                  FETCH_WIDTH = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input wire logic       clk,
  input wire logic       rst,
  fetch_pc_unit_if.slave bus
);

  localparam logic [PC_WIDTH-1:0] c_low_mask = PC_WIDTH'(FETCH_WIDTH - 1);
  localparam logic [PC_WIDTH-1:0] c_reset_pc = RESET_PC & ~c_low_mask;
  localparam logic [PC_WIDTH:0]   c_step     = (PC_WIDTH + 1)'(FETCH_WIDTH);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t                 r_state, w_state;
  logic [PC_WIDTH-1:0]    r_pc, w_pc;
  logic [PC_WIDTH-1:0]    r_pend_pc, w_pend_pc;
  logic [0:FETCH_WIDTH-1] r_mask, w_mask;
  logic                   r_valid, w_valid;
  logic                   r_pend, w_pend;
  logic                   r_misalign, w_misalign;
  logic                   r_wrap, w_wrap;

  logic                   w_redirect;
  logic [PC_WIDTH-1:0]    w_target;
  logic [PC_WIDTH-1:0]    w_off;
  logic [0:FETCH_WIDTH-1] w_tgt_mask;
  logic [PC_WIDTH:0]      w_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_BOOT;
      r_pc       <= c_reset_pc;
      r_pend_pc  <= '0;
      r_mask     <= '1;
      r_valid    <= 1'b0;
      r_pend     <= 1'b0;
      r_misalign <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_pend_pc  <= w_pend_pc;
      r_mask     <= w_mask;
      r_valid    <= w_valid;
      r_pend     <= w_pend;
      r_misalign <= w_misalign;
      r_wrap     <= w_wrap;
    end
  end

  // A buffered target always outranks a fresh one, so it feeds the shared aligner.
  always_comb begin
    w_redirect = bus.is_branch && bus.branch_taken;
    w_target   = r_pend ? r_pend_pc : bus.PC_in;
    w_off      = w_target & c_low_mask;
    w_sum      = {1'b0, r_pc} + c_step;
    w_tgt_mask = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_tgt_mask[i] = (PC_WIDTH'(i) >= w_off);
    end
  end

  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_pend_pc  = r_pend_pc;
    w_mask     = r_mask;
    w_valid    = r_valid;
    w_pend     = r_pend;
    w_misalign = 1'b0;
    w_wrap     = 1'b0;

    case (r_state)
      S_BOOT: begin
        w_state = S_RUN;
        w_valid = 1'b1;
        w_pc    = c_reset_pc;
        w_mask  = '1;
        w_pend  = 1'b0;
      end
      S_RUN: begin
        if (bus.halt) begin
          w_state = S_HALTED;
          w_valid = 1'b0;
          w_pend  = 1'b0;
        end else if (bus.stall) begin
          if (w_redirect && !r_pend) begin
            w_pend    = 1'b1;
            w_pend_pc = bus.PC_in;
          end
        end else if (r_pend || w_redirect) begin
          w_pc       = w_target & ~c_low_mask;
          w_mask     = w_tgt_mask;
          w_misalign = (w_off != '0);
          w_pend     = 1'b0;
        end else begin
          w_pc   = w_sum[PC_WIDTH-1:0];
          w_mask = '1;
          w_wrap = w_sum[PC_WIDTH];
        end
      end
      S_HALTED: begin
        if (!bus.halt && bus.resume) begin
          w_state = S_RUN;
          w_valid = 1'b1;
          w_mask  = '1;
        end
      end
      default: begin
        w_state = S_BOOT;
        w_valid = 1'b0;
      end
    endcase
  end

  assign bus.PC_out           = r_pc;
  assign bus.slot_mask        = r_mask;
  assign bus.fetch_valid      = r_valid;
  assign bus.redirect_pending = r_pend;
  assign bus.misalign         = r_misalign;
  assign bus.wrap             = r_wrap;

endmodule

`default_nettype wire
